// File: rtl/moore_o.sv
// Moore "101" sequence detector with overlap; z is decoded from the state register only.
// Optional MOORE_O_COUNT_EN adds a saturating 8-bit detect counter on port count.
module moore_o (
    output logic       z,
    input  logic       x,
    input  logic       clk,
    input  logic       reset
`ifdef MOORE_O_COUNT_EN
    ,
    output logic [7:0] count
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_e;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // An unknown x falls through to the default arm and parks the FSM in S0.
    always_comb begin
        state_d = S0;
        case (state_q)
            S0: begin
                case (x)
                    1'b1:    state_d = S1;
                    1'b0:    state_d = S0;
                    default: state_d = S0;
                endcase
            end
            S1: begin
                case (x)
                    1'b1:    state_d = S1;
                    1'b0:    state_d = S2;
                    default: state_d = S0;
                endcase
            end
            S2: begin
                case (x)
                    1'b1:    state_d = S3;
                    1'b0:    state_d = S0;
                    default: state_d = S0;
                endcase
            end
            S3: begin
                case (x)
                    1'b1:    state_d = S1;
                    1'b0:    state_d = S2;
                    default: state_d = S0;
                endcase
            end
            default: state_d = S0;
        endcase
    end

    assign z = (state_q == S3);

`ifdef MOORE_O_COUNT_EN
    logic [7:0] count_q;
    logic [7:0] count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if ((state_d == S3) && (count_q != '1)) begin
            count_d = count_q + 8'd1;
        end
    end

    assign count = count_q;
`endif

endmodule

// File: tb/tb_moore_o.sv
// Directed, table-driven bench for the moore_o "101" detector.
// Covers reset, overlap, near-miss patterns, mid-sequence and asynchronous reset.
module tb_moore_o;

    logic clk;
    logic reset;
    logic x;
    logic z;
`ifdef MOORE_O_COUNT_EN
    logic [7:0] count;
`endif

    int checks;
    int errors;

    moore_o dut (
        .z     (z),
        .x     (x),
        .clk   (clk),
        .reset (reset)
`ifdef MOORE_O_COUNT_EN
        ,
        .count (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic xin;
        logic z_exp;
    } vec_t;

    vec_t vecs [0:30];

    task automatic check_z(input string name, input logic exp);
        checks++;
        if (z !== exp) begin
            errors++;
            $display("FAIL %s: z=%b expected %b at %0t", name, z, exp, $time);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic rst, input logic xin);
        reset = rst;
        x     = xin;
        @(posedge clk);
        #1;
    endtask

`ifdef MOORE_O_COUNT_EN
    task automatic check_count(input string name, input logic [7:0] exp);
        checks++;
        if (count !== exp) begin
            errors++;
            $display("FAIL %s: count=%0d expected %0d at %0t", name, count, exp, $time);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;

        // Reset held, x toggling: z must stay low.
        vecs[0]  = '{1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0};
        // 1,0,1 then 1 -> S1
        vecs[5]  = '{1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0};
        // Overlap: 1,0,1,0,1
        vecs[9]  = '{1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1};
        // 1,1,0,1 -> single pulse on edge 4
        vecs[15] = '{1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 1'b0};
        // 1,0,0,1 -> no detect
        vecs[21] = '{1'b1, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 1'b1, 1'b0};
        // Reset sampled while in S3 drops z; 0,1 afterwards cannot detect.
        vecs[26] = '{1'b0, 1'b0, 1'b0};
        vecs[27] = '{1'b0, 1'b1, 1'b1};
        vecs[28] = '{1'b1, 1'b1, 1'b0};
        vecs[29] = '{1'b0, 1'b0, 1'b0};
        vecs[30] = '{1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        x     = 1'b0;
        #2;
        check_z("reset_async_initial", 1'b0);

        for (int i = 0; i <= 30; i++) begin
            step(vecs[i].rst, vecs[i].xin);
            check_z($sformatf("vec%0d", i), vecs[i].z_exp);
        end

        // Mid-sequence reset: progress "10" discarded, so a following 1 lands in S1.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        step(1'b0, 1'b1);
        check_z("midseq_reset_after_1", 1'b0);
        step(1'b0, 1'b0);
        check_z("midseq_reset_s2", 1'b0);
        step(1'b0, 1'b1);
        check_z("midseq_reset_redetect", 1'b1);

        // Asynchronous reset while in S3: z must fall before any clock edge.
        #1 reset = 1'b1;
        #1;
        check_z("async_reset_in_s3", 1'b0);
        step(1'b1, 1'b1);
        check_z("async_reset_held", 1'b0);

        // After release, first edge evaluates x from S0.
        step(1'b0, 1'b1);
        check_z("release_first_edge", 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check_z("release_detect", 1'b1);

`ifdef MOORE_O_COUNT_EN
        step(1'b1, 1'b0);
        check_count("count_reset", 8'd0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check_count("count_overlap_two", 8'd2);
        #1 reset = 1'b1;
        #1;
        check_count("count_async_clear", 8'd0);
        step(1'b0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
        check_count("count_saturate", 8'hFF);
        check_z("count_saturate_z", 1'b1);
        step(1'b1, 1'b0);
        check_count("count_after_reset", 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
